dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Shares the single-port synchronous dmem between two requesters: port 0 is the processor load/store path, port 1 is an auxiliary master (loader/DMA/IO).
- Sits between the processor's address_dmem/data/wren/q_dmem signals and the dmem instance.
- Arbitration uses fixed priority for port 0 plus a starvation counter that guarantees port 1 progress. It also provides a stall signal for the processor and routes read data back to the correct requester.

Parameters:
- ADDR_W, 12, dmem word address width
- DATA_W, 32, dmem data width
- STARVE_LIMIT, 4, consecutive cycles port 1 may be denied before it takes priority (legal range 1..15)

Ports:
- clock  in  1  master clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- p0_req  in  1  processor requests a dmem access this cycle
- p0_wren  in  1  1 = write, 0 = read; qualified by p0_req
- p0_addr  in  ADDR_W  processor word address
- p0_wdata  in  DATA_W  processor write data
- p0_gnt  out  1  access accepted this cycle
- p0_stall  out  1  p0_req & ~p0_gnt; processor freezes its PC and pipeline on this
- p0_rvalid  out  1  p0 read data valid (one cycle after the granted read)
- p0_rdata  out  DATA_W  read data for p0
- p1_req, p1_wren, p1_addr, p1_wdata  in  1/1/ADDR_W/DATA_W  auxiliary request, same meaning as the p0 fields
- p1_gnt, p1_rvalid  out  1  same meaning as the p0 outputs
- p1_rdata  out  DATA_W  read data for p1
- address_dmem  out  ADDR_W  to dmem address
- data  out  DATA_W  to dmem write data
- wren  out  1  to dmem write enable
- q_dmem  in  DATA_W  dmem read data (valid one clock after the address is presented)

Behaviour:
- Grant logic is combinational from the current req inputs and the registered starve_cnt:
  - p1_pri = (starve_cnt >= STARVE_LIMIT).
  - If p1_pri & p1_req, then p1 is granted.
  - Else if p0_req, then p0 is granted.
  - Else if p1_req, then p1 is granted.
  - Else nothing is granted.
  - Exactly zero or one grant per cycle.
- Mux:
  - address_dmem, data and wren come from the granted port.
  - When nothing is granted: address_dmem = 0, data = 0, wren = 0.
  - wren is also forced to 0 while reset is high.
- Requester rule: a requester holds req, wren, addr and wdata stable until it sees gnt. A deasserted req before gnt withdraws the request; this is legal and has no side effects.
- Writes complete on the granted cycle; no response follows.
- Reads:
  - A registered rd_owner[1:0] (one-hot) records the granted read.
  - In the next cycle, pN_rvalid = rd_owner[N] and pN_rdata = q_dmem.
  - pN_rdata is 0 whenever pN_rvalid = 0.
  - Back-to-back reads are allowed, one per cycle, fully pipelined.
- starve_cnt (4-bit register):
  - Resets to 0 when p1 is granted or p1_req = 0.
  - Increments (saturating at 15) when p1_req & ~p1_gnt.
  - Worst-case p1 wait is STARVE_LIMIT cycles.
- Simultaneous events:
  - When p1 wins on priority, p0_stall = 1 for that cycle only; p0 has priority again next cycle, since starve_cnt is back to 0.
  - Both ports requesting with the same address and one writing: the winner's access happens first. No forwarding is done.
- Reset values: starve_cnt = 0, rd_owner = 00. Therefore both rvalid = 0, both rdata = 0, wren = 0.
  - Grant outputs track the req inputs combinationally but are ignored during reset.
- Reset mid-operation: a read granted in the cycle before reset is dropped, with no rvalid issued. starve_cnt clears.
- Latency: grant 0 cycles; read data 1 cycle after grant. Throughput is one access per cycle.

Decomposition:
- Shared package (dmem_arb_pkg): ADDR_W/DATA_W defaults, port index constants PORT_CPU = 0 and PORT_AUX = 1, and the one-hot owner encoding.
- No sub-module; the starvation counter stays inline. The grant selector can be an internal function.

Test Plan:
- Only p0 reads addr 0x010 (mem = 0xDEADBEEF) → p0_gnt = 1 same cycle, p0_rvalid = 1 and p0_rdata = 0xDEADBEEF next cycle, p1_rvalid = 0.
- p0 and p1 request every cycle, STARVE_LIMIT = 4 → p1 denied 4 cycles, granted on the 5th with p0_stall = 1 that cycle only. The pattern repeats: 4 p0 grants, then 1 p1 grant.
- p1 writes 0x12345678 to 0x0FF, then p0 reads 0x0FF the next cycle → p0_rdata = 0x12345678 one cycle after its grant.
- Alternating p0/p1 back-to-back reads of distinct addresses → each rvalid goes only to the owner of the previous cycle's grant; no cross-delivery.
- p0 read granted, then reset asserted the next cycle → p0_rvalid = 0, wren = 0, starve_cnt = 0 after reset.
- No requests → address_dmem = 0, data = 0, wren = 0, both gnt = 0, both stall = 0.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// rtl/dmem_arb_pkg.sv - shared constants, owner encoding and grant selector for dmem_arbiter
package dmem_arb_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 32;

    // Requester indices into the one-hot grant/owner vectors
    localparam int PORT_CPU = 0;
    localparam int PORT_AUX = 1;

    // One-hot owner of the read whose data arrives this cycle
    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_CPU  = 2'b01,
        OWN_AUX  = 2'b10
    } owner_e;

    // Fixed priority to the CPU unless the aux port has been starved long enough
    function automatic logic [1:0] arb_grant(input logic p0_req, input logic p1_req,
                                             input logic p1_pri);
        logic [1:0] g;
        g = OWN_NONE;
        if (p1_pri && p1_req) begin
            g = OWN_AUX;
        end else if (p0_req) begin
            g = OWN_CPU;
        end else if (p1_req) begin
            g = OWN_AUX;
        end
        return g;
    endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port arbiter in front of the single-port synchronous dmem
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              p0_req,
    input  logic              p0_wren,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_gnt,
    output logic              p0_stall,
    output logic              p0_rvalid,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_wren,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_gnt,
    output logic              p1_rvalid,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] address_dmem,
    output logic [DATA_W-1:0] data,
    output logic              wren,
    input  logic [DATA_W-1:0] q_dmem
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic [3:0] starve_q, starve_d;
    logic [1:0] rd_owner_q, rd_owner_d;
    logic [1:0] gnt;
    logic       p1_pri;

    // Grant decision: combinational from live requests and the registered starvation count
    always_comb begin
        p1_pri   = (starve_q >= LIMIT);
        gnt      = arb_grant(p0_req, p1_req, p1_pri);
        p0_gnt   = gnt[PORT_CPU];
        p1_gnt   = gnt[PORT_AUX];
        p0_stall = p0_req & ~gnt[PORT_CPU];
    end

    // Steer the winner onto the dmem pins; idle bus is all zero and writes are blocked in reset
    always_comb begin
        address_dmem = '0;
        data         = '0;
        wren         = 1'b0;
        if (gnt[PORT_AUX]) begin
            address_dmem = p1_addr;
            data         = p1_wdata;
            wren         = p1_wren & ~reset;
        end else if (gnt[PORT_CPU]) begin
            address_dmem = p0_addr;
            data         = p0_wdata;
            wren         = p0_wren & ~reset;
        end
    end

    // Return read data to whoever owned last cycle's read; a read in flight at reset is dropped
    always_comb begin
        p0_rvalid = rd_owner_q[PORT_CPU] & ~reset;
        p1_rvalid = rd_owner_q[PORT_AUX] & ~reset;
        p0_rdata  = p0_rvalid ? q_dmem : '0;
        p1_rdata  = p1_rvalid ? q_dmem : '0;
    end

    // Next state: read ownership and the saturating count of consecutive aux denials
    always_comb begin
        rd_owner_d = OWN_NONE;
        if (gnt[PORT_AUX] && !p1_wren) begin
            rd_owner_d = OWN_AUX;
        end else if (gnt[PORT_CPU] && !p0_wren) begin
            rd_owner_d = OWN_CPU;
        end

        starve_d = starve_q;
        if (!p1_req || gnt[PORT_AUX]) begin
            starve_d = 4'd0;
        end else if (starve_q != 4'hF) begin
            starve_d = starve_q + 4'd1;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            starve_q   <= 4'd0;
            rd_owner_q <= OWN_NONE;
        end else begin
            starve_q   <= starve_d;
            rd_owner_q <= rd_owner_d;
        end
    end

endmodule
